regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (wn/d/we) among three sources: debug, core

---
 rtl/regfile_wb_arbiter_if.sv | 53 +++++
 rtl/regfile_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-port bundle between the writeback sources, the register file and the
// core's hazard logic. 'slave' is the arbiter side; 'master' is the side that
// drives requests and consumes grants and hazard flags.
//
// Handshake: a request moves on a rising clk edge where its valid and ready
// are both high. Once valid is raised, the source keeps valid and its
// payload (wn/d) steady until it sees ready. dbg_ready and c_ready are
// combinational grants. l_ready is simply "FIFO not full" and does not
// depend on l_valid. iss_valid has no ready: every issue is taken.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              dbg_valid;
   logic [4:0]        dbg_wn;
   logic [DATA_W-1:0] dbg_d;
   logic              dbg_ready;
   logic              c_valid;
   logic [4:0]        c_wn;
   logic [DATA_W-1:0] c_d;
   logic              c_ready;
   logic              l_valid;
   logic [4:0]        l_wn;
   logic [DATA_W-1:0] l_d;
   logic              l_ready;
   logic              iss_valid;
   logic [4:0]        iss_wn;
   logic [4:0]        rna;
   logic [4:0]        rnb;
   logic              haz_a;
   logic              haz_b;
   logic [4:0]        rf_wn;
   logic [DATA_W-1:0] rf_d;
   logic              rf_we;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              arb_force;   // arbiter FSM state: 1 = FORCE

   modport slave (
      input  dbg_valid, dbg_wn, dbg_d, c_valid, c_wn, c_d,
             l_valid, l_wn, l_d, iss_valid, iss_wn, rna, rnb,
      output dbg_ready, c_ready, l_ready, haz_a, haz_b,
             rf_wn, rf_d, rf_we, fifo_cnt, arb_force
   );

   modport master (
      output dbg_valid, dbg_wn, dbg_d, c_valid, c_wn, c_d,
             l_valid, l_wn, l_d, iss_valid, iss_wn, rna, rnb,
      input  dbg_ready, c_ready, l_ready, haz_a, haz_b,
             rf_wn, rf_d, rf_we, fifo_cnt, arb_force
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: debug, core writeback and a FIFO-buffered
// long-latency source share one registered write port. An age counter forces
// the FIFO head through after it has lost STARVE_LIMIT times in a row, and a
// pending-write scoreboard drives the read-port hazard flags.
module regfile_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                clrn,
   regfile_wb_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [AGE_W-1:0]  age_q, age_d;
   logic [DATA_W-1:0] mem_d  [FIFO_DEPTH];
   logic [4:0]        mem_wn [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       sb_q, sb_d;
   logic              full, empty, push, pop;
   logic              gnt_dbg, gnt_core, gnt_head, any_gnt;
   logic [4:0]        head_wn, wr_wn;
   logic [DATA_W-1:0] head_d, wr_d;
   logic              rf_we_q;
   logic [4:0]        rf_wn_q;
   logic [DATA_W-1:0] rf_d_q;

   assign full    = (cnt_q == CNT_FULL);
   assign empty   = (cnt_q == '0);
   assign push    = bus.l_valid && !full;
   assign head_wn = mem_wn[rd_ptr_q];
   assign head_d  = mem_d[rd_ptr_q];

   // Grant selection, age update and FSM next state.
   always_comb begin
      state_d  = state_q;
      age_d    = age_q;
      gnt_dbg  = 1'b0;
      gnt_core = 1'b0;
      gnt_head = 1'b0;
      case (state_q)
         NORMAL: begin
            if (bus.dbg_valid)    gnt_dbg  = 1'b1;
            else if (bus.c_valid) gnt_core = 1'b1;
            else if (!empty)      gnt_head = 1'b1;
         end
         FORCE: begin
            if (!empty)             gnt_head = 1'b1;
            else if (bus.dbg_valid) gnt_dbg  = 1'b1;
            else if (bus.c_valid)   gnt_core = 1'b1;
         end
         default: ;
      endcase
      pop = gnt_head;
      // The age counts consecutive losses of the current head.
      if (empty || pop)          age_d = '0;
      else if (age_q != AGE_MAX) age_d = age_q + 1'b1;
      // FORCE is entered on the edge where the head collects its last allowed loss.
      case (state_q)
         NORMAL:  if (age_d == AGE_MAX) state_d = FORCE;
         FORCE:   if (pop || empty)     state_d = NORMAL;
         default: state_d = NORMAL;
      endcase
   end

   // Mux the granted source onto the write path.
   always_comb begin
      wr_wn   = 5'd0;
      wr_d    = '0;
      any_gnt = gnt_dbg || gnt_core || gnt_head;
      if (gnt_dbg) begin
         wr_wn = bus.dbg_wn;
         wr_d  = bus.dbg_d;
      end else if (gnt_core) begin
         wr_wn = bus.c_wn;
         wr_d  = bus.c_d;
      end else if (gnt_head) begin
         wr_wn = head_wn;
         wr_d  = head_d;
      end
   end

   // FSM state and age counter registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= NORMAL;
         age_q   <= '0;
      end else begin
         state_q <= state_d;
         age_q   <= age_d;
      end
   end

   // FIFO pointers and occupancy; push and pop may coincide when not full.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // FIFO storage; contents are meaningless while unoccupied, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_wn[wr_ptr_q] <= bus.l_wn;
         mem_d[wr_ptr_q]  <= bus.l_d;
      end
   end

   // Scoreboard next value: clear on FIFO pop, then set on issue so a same-register set wins.
   always_comb begin
      sb_d = sb_q;
      if (pop) sb_d[head_wn] = 1'b0;
      if (bus.iss_valid && (bus.iss_wn != 5'd0)) sb_d[bus.iss_wn] = 1'b1;
      sb_d[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) sb_q <= '0;
      else       sb_q <= sb_d;
   end

   // Output register: one-cycle write latency, writes to r0 are swallowed.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rf_we_q <= 1'b0;
         rf_wn_q <= 5'd0;
         rf_d_q  <= '0;
      end else begin
         rf_we_q <= any_gnt && (wr_wn != 5'd0);
         if (any_gnt) begin
            rf_wn_q <= wr_wn;
            rf_d_q  <= wr_d;
         end
      end
   end

   assign bus.dbg_ready = gnt_dbg;
   assign bus.c_ready   = gnt_core;
   assign bus.l_ready   = !full;
   assign bus.haz_a     = sb_q[bus.rna];
   assign bus.haz_b     = sb_q[bus.rnb];
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_wn     = rf_wn_q;
   assign bus.rf_d      = rf_d_q;
   assign bus.fifo_cnt  = cnt_q;
   assign bus.arb_force = (state_q == FORCE);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic with occasional resets, all checked against a
// queue-based behavioural model once per cycle on the falling edge.
module tb_regfile_wb_arbiter;
   localparam int DATA_W       = 32;
   localparam int FIFO_DEPTH   = 2;
   localparam int STARVE_LIMIT = 4;
   localparam int W            = 6 + DATA_W;   // {we, wn, d}

   logic clk  = 1'b0;
   logic clrn = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus();

   regfile_wb_arbiter #(
      .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk),
      .clrn(clrn),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      bus.dbg_valid = 1'b0; bus.dbg_wn = 5'd0; bus.dbg_d = '0;
      bus.c_valid   = 1'b0; bus.c_wn   = 5'd0; bus.c_d   = '0;
      bus.l_valid   = 1'b0; bus.l_wn   = 5'd0; bus.l_d   = '0;
      bus.iss_valid = 1'b0; bus.iss_wn = 5'd0;
      bus.rna       = 5'd0; bus.rnb    = 5'd0;
   endtask

   // Advance to just after the next rising edge; inputs change only here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      bus.dbg_valid = ($urandom_range(0, 9) == 0);
      bus.dbg_wn    = 5'($urandom_range(0, 31));
      bus.dbg_d     = DATA_W'($urandom);
      bus.c_valid   = ($urandom_range(0, 2) != 0);
      bus.c_wn      = 5'($urandom_range(0, 31));
      bus.c_d       = DATA_W'($urandom);
      bus.l_valid   = ($urandom_range(0, 1) != 0);
      bus.l_wn      = 5'($urandom_range(0, 7));
      bus.l_d       = DATA_W'($urandom);
      bus.iss_valid = ($urandom_range(0, 2) == 0);
      bus.iss_wn    = 5'($urandom_range(0, 7));
      bus.rna       = 5'($urandom_range(0, 7));
      bus.rnb       = 5'($urandom_range(0, 7));
   endtask

   // ---------------- scoreboard / reference model ----------------
   typedef struct packed {
      logic [4:0]        wn;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t           fq[$];        // long-latency results waiting, oldest first
   logic [W-1:0]   exp_q[$];     // register-file write expected next cycle
   bit             pend[32];     // registers with an outstanding long-latency write
   int             losses;       // consecutive lost arbitration rounds of the head
   int             g;            // 0 none, 1 debug, 2 core, 3 FIFO head
   bit             head_ok, forcing, exp_lrdy;
   logic [4:0]     g_wn;
   logic [DATA_W-1:0] g_d;
   logic [W-1:0]   e;
   ent_t           h;

   initial begin
      forever begin
         @(negedge clk);
         if (!clrn) begin
            fq.delete();
            exp_q.delete();
            foreach (pend[i]) pend[i] = 1'b0;
            losses = 0;
         end
         head_ok  = (fq.size() > 0);
         forcing  = head_ok && (losses >= STARVE_LIMIT);
         exp_lrdy = (fq.size() < FIFO_DEPTH);
         if (forcing)            g = 3;
         else if (bus.dbg_valid) g = 1;
         else if (bus.c_valid)   g = 2;
         else if (head_ok)       g = 3;
         else                    g = 0;
         g_wn = 5'd0;
         g_d  = '0;
         if (g == 1) begin g_wn = bus.dbg_wn; g_d = bus.dbg_d; end
         if (g == 2) begin g_wn = bus.c_wn;   g_d = bus.c_d;   end
         if (g == 3) begin g_wn = fq[0].wn;   g_d = fq[0].d;   end

         chk("dbg_ready", bus.dbg_ready, 64'(g == 1));
         chk("c_ready",   bus.c_ready,   64'(g == 2));
         chk("l_ready",   bus.l_ready,   64'(exp_lrdy));
         chk("fifo_cnt",  bus.fifo_cnt,  64'(fq.size()));
         chk("arb_force", bus.arb_force, 64'(forcing));
         chk("haz_a", bus.haz_a, 64'((bus.rna != 5'd0) && pend[bus.rna]));
         chk("haz_b", bus.haz_b, 64'((bus.rnb != 5'd0) && pend[bus.rnb]));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", bus.rf_we, 64'(e[W-1]));
            if (e[W-1]) begin
               chk("rf_wn", bus.rf_wn, 64'(e[W-2 -: 5]));
               chk("rf_d",  bus.rf_d,  64'(e[DATA_W-1:0]));
            end
         end else begin
            chk("rf_we_idle", bus.rf_we, 64'(0));
         end

         // Advance the model across the coming rising edge.
         if (clrn) begin
            exp_q.push_back({(g != 0) && (g_wn != 5'd0), g_wn, g_d});
            if (g == 3) begin
               h = fq.pop_front();
               pend[h.wn] = 1'b0;
            end
            if (bus.l_valid && exp_lrdy) fq.push_back({bus.l_wn, bus.l_d});
            if (bus.iss_valid && (bus.iss_wn != 5'd0)) pend[bus.iss_wn] = 1'b1;
            if (!head_ok || (g == 3))       losses = 0;
            else if (losses < STARVE_LIMIT) losses++;
         end
      end
   end

   // ---------------- stimulus with literal expectations ----------------
   initial begin
      set_idle();
      clrn = 1'b0;
      repeat (3) @(posedge clk);
      #1 clrn = 1'b1;

      // Priority: debug beats core, core follows next cycle.
      bus.dbg_valid = 1'b1; bus.dbg_wn = 5'd3; bus.dbg_d = 32'hD;
      bus.c_valid   = 1'b1; bus.c_wn   = 5'd4; bus.c_d   = 32'hC;
      #1;
      chk("prio_dbg_ready", bus.dbg_ready, 1);
      chk("prio_c_ready",   bus.c_ready,   0);
      step();
      bus.dbg_valid = 1'b0;
      #1;
      chk("prio_rf_we1", bus.rf_we, 1);
      chk("prio_rf_wn1", bus.rf_wn, 3);
      chk("prio_rf_d1",  bus.rf_d,  32'hD);
      chk("prio_c_ready2", bus.c_ready, 1);
      step();
      bus.c_valid = 1'b0;
      #1;
      chk("prio_rf_wn2", bus.rf_wn, 4);
      chk("prio_rf_d2",  bus.rf_d,  32'hC);
      step();

      // r0 write is accepted but never reaches the register file.
      bus.c_valid = 1'b1; bus.c_wn = 5'd0; bus.c_d = 32'hFFFF;
      #1;
      chk("r0_c_ready", bus.c_ready, 1);
      step();
      bus.c_valid = 1'b0;
      #1;
      chk("r0_rf_we", bus.rf_we, 0);
      step();

      // FIFO fill under constant core traffic, then starvation relief.
      bus.c_valid = 1'b1; bus.c_wn = 5'd1; bus.c_d = 32'h1;
      bus.l_valid = 1'b1; bus.l_wn = 5'd5; bus.l_d = 32'h55;
      #1;
      chk("full_l_ready0", bus.l_ready, 1);
      step();
      bus.l_wn = 5'd6; bus.l_d = 32'h66;
      step();
      bus.l_wn = 5'd8; bus.l_d = 32'h88;
      #1;
      chk("full_cnt", bus.fifo_cnt, 2);
      chk("full_l_ready", bus.l_ready, 0);
      step();
      #1;
      chk("full_third_ignored", bus.fifo_cnt, 2);
      bus.l_valid = 1'b0;
      step();
      #1;
      chk("starve_loss4_core", bus.c_ready, 1);
      step();
      #1;
      chk("starve_force_c_ready", bus.c_ready, 0);
      chk("starve_force_state", bus.arb_force, 1);
      step();
      bus.c_valid = 1'b0;
      #1;
      chk("starve_rf_we", bus.rf_we, 1);
      chk("starve_rf_wn", bus.rf_wn, 5);
      chk("starve_rf_d",  bus.rf_d,  32'h55);
      chk("starve_back_normal", bus.arb_force, 0);
      chk("starve_cnt", bus.fifo_cnt, 1);
      repeat (3) step();

      // Scoreboard set, clear on pop, and set-wins-over-clear.
      bus.iss_valid = 1'b1; bus.iss_wn = 5'd7;
      step();
      bus.iss_valid = 1'b0;
      bus.rna = 5'd7;
      #1;
      chk("sb_set", bus.haz_a, 1);
      bus.l_valid = 1'b1; bus.l_wn = 5'd7; bus.l_d = 32'h77;
      step();
      bus.l_valid = 1'b0;
      #1;
      chk("sb_before_pop", bus.haz_a, 1);
      step();
      #1;
      chk("sb_cleared", bus.haz_a, 0);
      bus.iss_valid = 1'b1; bus.iss_wn = 5'd7;
      bus.l_valid = 1'b1; bus.l_wn = 5'd7; bus.l_d = 32'h78;
      step();
      bus.l_valid = 1'b0;
      #1;
      chk("sb_pop_cycle", bus.fifo_cnt, 1);
      step();
      bus.iss_valid = 1'b0;
      #1;
      chk("sb_set_wins", bus.haz_a, 1);
      bus.rna = 5'd0;
      #1;
      chk("sb_r0", bus.haz_a, 0);

      // Asynchronous reset in the middle of a write with FIFO and scoreboard busy.
      bus.rna = 5'd7; bus.rnb = 5'd7;
      bus.c_valid = 1'b1; bus.c_wn = 5'd2; bus.c_d = 32'h22;
      bus.l_valid = 1'b1; bus.l_wn = 5'd9; bus.l_d = 32'h99;
      step();
      bus.l_valid = 1'b0;
      #1;
      chk("rst_pre_we",  bus.rf_we, 1);
      chk("rst_pre_cnt", bus.fifo_cnt, 1);
      chk("rst_pre_haz", bus.haz_b, 1);
      clrn = 1'b0;
      #1;
      chk("rst_rf_we", bus.rf_we, 0);
      chk("rst_cnt",   bus.fifo_cnt, 0);
      chk("rst_haz_a", bus.haz_a, 0);
      chk("rst_haz_b", bus.haz_b, 0);
      set_idle();
      step();
      clrn = 1'b1;

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         step();
         rand_inputs();
         if (!clrn)                              clrn = 1'b1;
         else if ($urandom_range(0, 299) == 0)   clrn = 1'b0;
      end

      set_idle();
      clrn = 1'b1;
      repeat (8) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
